// File: rtl/clk_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_pkg
// Shared definitions for the UART clock-divider configuration sequencer:
//   - sequencer state enum
//   - legal UART prescale values
//   - prescale -> {rx_bypass, rx_ratio} mapping function
//   - minimum usable divider ratio and sequencer counter width
// -----------------------------------------------------------------------------
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    localparam logic [5:0] PRESCALE_4  = 6'd4;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // A ratio of 0 or 1 cannot be produced by the 4-bit dividers.
    localparam logic [3:0] MIN_DIV_RATIO = 4'd2;

    // Wide enough for the drain count (>= 15) and the settle count.
    localparam int CNT_W = 5;

    // The RX divider runs at 32x oversampling of the ref-clock-relative rate,
    // so its ratio is 32/prescale; prescale 32 means ref clock passes straight
    // through. Unmapped values give {0, 0}.
    function automatic logic [4:0] prescale_to_rx(input logic [5:0] prescale);
        logic [4:0] res;
        case (prescale)
            PRESCALE_4:  res = {1'b0, 4'd8};
            PRESCALE_8:  res = {1'b0, 4'd4};
            PRESCALE_16: res = {1'b0, 4'd2};
            PRESCALE_32: res = {1'b1, 4'd1};
            default:     res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_map.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_map
// Combinational prescale decoder.
// Ports:
//   i_prescale   in  6  requested UART prescale
//   o_rx_ratio   out 4  RX divider ratio for that prescale (0 if unmapped)
//   o_rx_bypass  out 1  RX clock taken straight from the ref clock
//   o_invalid    out 1  prescale is not one of 4/8/16/32
// -----------------------------------------------------------------------------
module clk_div_ctrl_map
    import clk_div_ctrl_pkg::*;
(
    input  logic [5:0] i_prescale,
    output logic [3:0] o_rx_ratio,
    output logic       o_rx_bypass,
    output logic       o_invalid
);

    always_comb begin
        {o_rx_bypass, o_rx_ratio} = prescale_to_rx(i_prescale);
        o_invalid = 1'b1;
        case (i_prescale)
            PRESCALE_4, PRESCALE_8, PRESCALE_16, PRESCALE_32: o_invalid = 1'b0;
            default:                                          o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Sequencer owning the UART TX/RX clock-divider configuration. A new TX ratio
// and prescale are accepted over valid/ready; the dividers are then disabled,
// drained, reloaded and re-enabled so that ratios never change while enabled.
//
// Optional feature macro: CLK_DIV_CTRL_CFG_CHECK_EN
//   defined   : requests with tx_ratio < 2 or an unmapped prescale are rejected
//               with a one-cycle o_cfg_err pulse; configuration is kept.
//   undefined : no checking, o_cfg_err stays 0, values loaded as given.
//
// Ports:
//   i_ref_clk       in  1  reference clock (only clock)
//   i_rst           in  1  synchronous active-high reset
//   i_sys_en        in  1  system-level divider enable
//   i_cfg_valid     in  1  configuration request
//   o_cfg_ready     out 1  request can be accepted (IDLE only)
//   i_tx_ratio      in  4  requested TX divide ratio
//   i_prescale      in  6  requested UART prescale
//   o_tx_div_ratio  out 4  TX divider ratio
//   o_rx_div_ratio  out 4  RX divider ratio
//   o_rx_bypass     out 1  RX clock = ref clock
//   o_clk_en        out 1  enable to both dividers
//   o_busy          out 1  reconfiguration in progress
//   o_cfg_err       out 1  one-cycle pulse on a rejected request
// -----------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int         DRAIN_CYC    = 16,
    parameter int         SETTLE_CYC   = 2,
    parameter logic [3:0] DEF_TX_RATIO = 4'd8,
    parameter logic [5:0] DEF_PRESCALE = 6'd32
) (
    input  logic       i_ref_clk,
    input  logic       i_rst,
    input  logic       i_sys_en,
    input  logic       i_cfg_valid,
    output logic       o_cfg_ready,
    input  logic [3:0] i_tx_ratio,
    input  logic [5:0] i_prescale,
    output logic [3:0] o_tx_div_ratio,
    output logic [3:0] o_rx_div_ratio,
    output logic       o_rx_bypass,
    output logic       o_clk_en,
    output logic       o_busy,
    output logic       o_cfg_err
);

    localparam logic [4:0]       DEF_RX    = prescale_to_rx(DEF_PRESCALE);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Captured request, held until the LOAD transition.
    logic [3:0] tx_req_q, tx_req_d;
    logic [3:0] rx_req_q, rx_req_d;
    logic       byp_req_q, byp_req_d;

    // Divider-facing configuration.
    logic [3:0] tx_ratio_q, tx_ratio_d;
    logic [3:0] rx_ratio_q, rx_ratio_d;
    logic       rx_byp_q, rx_byp_d;
    logic       clk_en_q, clk_en_d;
    logic       err_q, err_d;

    logic [3:0] map_rx_ratio;
    logic       map_rx_bypass;
    logic       map_invalid;
    logic       req_bad;

    clk_div_ctrl_map u_map (
        .i_prescale  (i_prescale),
        .o_rx_ratio  (map_rx_ratio),
        .o_rx_bypass (map_rx_bypass),
        .o_invalid   (map_invalid)
    );

`ifdef CLK_DIV_CTRL_CFG_CHECK_EN
    assign req_bad = (i_tx_ratio < MIN_DIV_RATIO) | map_invalid;
`else
    logic unused_map_invalid;
    assign unused_map_invalid = map_invalid;
    assign req_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_req_d   = tx_req_q;
        rx_req_d   = rx_req_q;
        byp_req_d  = byp_req_q;
        tx_ratio_d = tx_ratio_q;
        rx_ratio_d = rx_ratio_q;
        rx_byp_d   = rx_byp_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_cfg_valid) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_DRAIN;
                        cnt_d     = DRAIN_LD;
                        tx_req_d  = i_tx_ratio;
                        rx_req_d  = map_rx_ratio;
                        byp_req_d = map_rx_bypass;
                    end
                end
            end
            ST_DRAIN: begin
                // Ratios are written on the edge that enters LOAD so they are
                // already stable for the whole LOAD cycle, with dividers off.
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_LOAD;
                    tx_ratio_d = tx_req_q;
                    rx_ratio_d = rx_req_q;
                    rx_byp_d   = byp_req_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
                cnt_d   = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Enable is registered from the state being entered, so it drops on
        // the accept edge and only returns once the new ratios are in place.
        clk_en_d = ((state_d == ST_IDLE) || (state_d == ST_SETTLE)) & i_sys_en;
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_req_q   <= DEF_TX_RATIO;
            rx_req_q   <= DEF_RX[3:0];
            byp_req_q  <= DEF_RX[4];
            tx_ratio_q <= DEF_TX_RATIO;
            rx_ratio_q <= DEF_RX[3:0];
            rx_byp_q   <= DEF_RX[4];
            clk_en_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_req_q   <= tx_req_d;
            rx_req_q   <= rx_req_d;
            byp_req_q  <= byp_req_d;
            tx_ratio_q <= tx_ratio_d;
            rx_ratio_q <= rx_ratio_d;
            rx_byp_q   <= rx_byp_d;
            clk_en_q   <= clk_en_d;
            err_q      <= err_d;
        end
    end

    assign o_cfg_ready    = (state_q == ST_IDLE);
    assign o_busy         = (state_q != ST_IDLE);
    assign o_tx_div_ratio = tx_ratio_q;
    assign o_rx_div_ratio = rx_ratio_q;
    assign o_rx_bypass    = rx_byp_q;
    assign o_clk_en       = clk_en_q;
    assign o_cfg_err      = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl with default parameters. Expected
// outputs come from a cycle-indexed model of the reconfiguration timeline and
// a 32/prescale arithmetic mapping. Honors CLK_DIV_CTRL_CFG_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sys_en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] tx_ratio_in;
    logic [5:0] prescale_in;
    logic [3:0] tx_div;
    logic [3:0] rx_div;
    logic       rx_byp;
    logic       clk_en;
    logic       busy;
    logic       cfg_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model of the currently applied configuration.
    logic [3:0] m_tx;
    logic [3:0] m_rx;
    logic       m_byp;

    always #5 clk = ~clk;

    clk_div_ctrl dut (
        .i_ref_clk      (clk),
        .i_rst          (rst),
        .i_sys_en       (sys_en),
        .i_cfg_valid    (cfg_valid),
        .o_cfg_ready    (cfg_ready),
        .i_tx_ratio     (tx_ratio_in),
        .i_prescale     (prescale_in),
        .o_tx_div_ratio (tx_div),
        .o_rx_div_ratio (rx_div),
        .o_rx_bypass    (rx_byp),
        .o_clk_en       (clk_en),
        .o_busy         (busy),
        .o_cfg_err      (cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pre_ok(input logic [5:0] p);
        return (p == 6'd4) || (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
    endfunction

    task automatic set_defaults_model();
        m_tx  = 4'd8;
        m_rx  = 4'd1;
        m_byp = 1'b1;
    endtask

    // One full reconfiguration from the accept edge (k) to IDLE (k+19).
    // drop_at: cycle index j whose edge sees i_sys_en=0 (0 = never).
    // hold_next: keep a second request (tx2/pre2) asserted throughout.
    task automatic do_seq(input logic [3:0] tx, input logic [5:0] pre,
                          input int drop_at, input bit hold_next,
                          input logic [3:0] tx2, input logic [5:0] pre2);
        logic [3:0] n_tx, n_rx, e_tx, e_rx;
        logic       n_byp, e_byp, e_busy, e_en, sys;
        n_tx  = tx;
        n_rx  = pre_ok(pre) ? 4'(32 / pre) : 4'd0;
        n_byp = (pre == 6'd32);

        tx_ratio_in = tx;
        prescale_in = pre;
        cfg_valid   = 1'b1;
        tick();
        chk_cnt++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || clk_en !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL accept tx=%0d pre=%0d: busy=%b ready=%b en=%b err=%b, want 1 0 0 0",
                     tx, pre, busy, cfg_ready, clk_en, cfg_err);
        else pass_cnt++;

        if (hold_next) begin
            tx_ratio_in = tx2;
            prescale_in = pre2;
        end else begin
            cfg_valid = 1'b0;
        end

        for (int j = 1; j <= 19; j++) begin
            if (j == drop_at) sys_en = 1'b0;
            sys = sys_en;
            tick();
            e_busy = (j < 19);
            e_en   = (j >= 17) ? sys : 1'b0;
            e_tx   = (j >= 16) ? n_tx  : m_tx;
            e_rx   = (j >= 16) ? n_rx  : m_rx;
            e_byp  = (j >= 16) ? n_byp : m_byp;
            chk_cnt++;
            if (busy !== e_busy || cfg_ready !== !e_busy || clk_en !== e_en ||
                tx_div !== e_tx || rx_div !== e_rx || rx_byp !== e_byp || cfg_err !== 1'b0)
                $display("FAIL seq j=%0d: busy=%b ready=%b en=%b tx=%0d rx=%0d byp=%b err=%b, want busy=%b ready=%b en=%b tx=%0d rx=%0d byp=%b err=0",
                         j, busy, cfg_ready, clk_en, tx_div, rx_div, rx_byp, cfg_err,
                         e_busy, !e_busy, e_en, e_tx, e_rx, e_byp);
            else pass_cnt++;
        end
        m_tx  = n_tx;
        m_rx  = n_rx;
        m_byp = n_byp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sys_en = 1'b1;
        cfg_valid = 1'b0;
        tx_ratio_in = 4'd0;
        prescale_in = 6'd0;
        tick();
        tick();
        set_defaults_model();
        chk_cnt++;
        if (tx_div !== 4'd8 || rx_div !== 4'd1 || rx_byp !== 1'b1 || cfg_ready !== 1'b1 ||
            busy !== 1'b0 || clk_en !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL reset: tx=%0d rx=%0d byp=%b ready=%b busy=%b en=%b err=%b, want 8 1 1 1 0 0 0",
                     tx_div, rx_div, rx_byp, cfg_ready, busy, clk_en, cfg_err);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (clk_en !== 1'b1) $display("FAIL reset_en: en=%b, want 1", clk_en);
        else pass_cnt++;
    endtask

    task automatic test_reconfig();
        logic [3:0] tx;
        logic [5:0] pre;
        do_seq(4'd6, 6'd8, 0, 1'b0, 4'd0, 6'd0);
        for (int n = 0; n < 5; n++) begin
            tx  = 4'($urandom_range(2, 15));
            pre = 6'(4 << $urandom_range(0, 3));
            do_seq(tx, pre, 0, 1'b0, 4'd0, 6'd0);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_seq(4'd3, 6'd16, 0, 1'b1, 4'd11, 6'd4);
        do_seq(4'd11, 6'd4, 0, 1'b0, 4'd0, 6'd0);
    endtask

    task automatic test_sys_en_settle();
        do_seq(4'd5, 6'd32, 18, 1'b0, 4'd0, 6'd0);
        sys_en = 1'b1;
        tick();
        chk_cnt++;
        if (clk_en !== 1'b1 || busy !== 1'b0)
            $display("FAIL sys_en_restore: en=%b busy=%b, want 1 0", clk_en, busy);
        else pass_cnt++;
    endtask

    task automatic test_bad_request();
`ifdef CLK_DIV_CTRL_CFG_CHECK_EN
        logic [3:0] btx [2] = '{4'd1, 4'd5};
        logic [5:0] bpre[2] = '{6'd8, 6'd12};
        for (int n = 0; n < 2; n++) begin
            tx_ratio_in = btx[n];
            prescale_in = bpre[n];
            cfg_valid   = 1'b1;
            tick();
            chk_cnt++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
                tx_div !== m_tx || rx_div !== m_rx || rx_byp !== m_byp)
                $display("FAIL reject%0d: err=%b busy=%b ready=%b tx=%0d rx=%0d byp=%b, want 1 0 1 %0d %0d %b",
                         n, cfg_err, busy, cfg_ready, tx_div, rx_div, rx_byp, m_tx, m_rx, m_byp);
            else pass_cnt++;
        end
        // Valid request issued in the cycle right after a rejection.
        do_seq(4'd9, 6'd16, 0, 1'b0, 4'd0, 6'd0);
`else
        do_seq(4'd1, 6'd12, 0, 1'b0, 4'd0, 6'd0);
        do_seq(4'd7, 6'd8, 0, 1'b0, 4'd0, 6'd0);
`endif
    endtask

    task automatic test_rst_mid();
        tx_ratio_in = 4'd13;
        prescale_in = 6'd4;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        rst = 1'b1;
        tick();
        set_defaults_model();
        chk_cnt++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || tx_div !== 4'd8 || rx_div !== 4'd1 ||
            rx_byp !== 1'b1 || clk_en !== 1'b0)
            $display("FAIL rst_mid: busy=%b ready=%b tx=%0d rx=%0d byp=%b en=%b, want 0 1 8 1 1 0",
                     busy, cfg_ready, tx_div, rx_div, rx_byp, clk_en);
        else pass_cnt++;
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            chk_cnt++;
            if (busy !== 1'b0 || tx_div !== m_tx || rx_div !== m_rx || rx_byp !== m_byp || clk_en !== 1'b1)
                $display("FAIL rst_discard j=%0d: busy=%b tx=%0d rx=%0d byp=%b en=%b, want 0 %0d %0d %b 1",
                         j, busy, tx_div, rx_div, rx_byp, clk_en, m_tx, m_rx, m_byp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_reconfig();
        test_back_to_back();
        test_sys_en_settle();
        test_bad_request();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Sequencer that owns the configuration of the UART TX and RX clock dividers. It accepts a new TX divide ratio and UART prescale from the register file over a valid/ready handshake, and derives the RX divide ratio from the prescale. Each change is applied glitch-free: the dividers are disabled, drained, reloaded, then re-enabled. It sits between the register file and the two divider instances in the clock-generation area.

## Interface
Parameters:
- DRAIN_CYC, 16: ref-clock cycles dividers are held disabled before reload; must be ≥15 (longest 4-bit divider period).
- SETTLE_CYC, 2: cycles after re-enable before the block reports idle.
- DEF_TX_RATIO, 4'd8: TX ratio after reset.
- DEF_PRESCALE, 6'd32: prescale after reset.

Ports:
- i_ref_clk  in  1  reference clock; sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_sys_en  in  1  system-level divider enable.
- i_cfg_valid  in  1  config request.
- o_cfg_ready  out  1  block can accept a request.
- i_tx_ratio  in  4  requested TX divide ratio.
- i_prescale  in  6  requested UART prescale (4/8/16/32).
- o_tx_div_ratio  out  4  to TX divider.
- o_rx_div_ratio  out  4  to RX divider.
- o_rx_bypass  out  1  RX clock = ref clock (divider unused).
- o_clk_en  out  1  enable to both dividers.
- o_busy  out  1  reconfiguration in progress.
- o_cfg_err  out  1  one-cycle pulse: request rejected.

## Operation
- States: IDLE, DRAIN, LOAD, SETTLE. Two-bit state register. One down-counter, 5 bits wide, sized for max(DRAIN_CYC, SETTLE_CYC).
- Reset values:
  - state IDLE, o_tx_div_ratio=DEF_TX_RATIO.
  - RX ratio and bypass from DEF_PRESCALE mapping: 1 and 1 for the default of 32.
  - o_clk_en=0, o_busy=0, o_cfg_ready=1, o_cfg_err=0.
- Prescale → RX ratio mapping:
  - 4→8, 8→4, 16→2: o_rx_bypass=0.
  - 32→ratio 1, o_rx_bypass=1.
- IDLE:
  - o_cfg_ready=1. o_clk_en follows i_sys_en (registered, 1-cycle delay).
  - On i_cfg_valid & o_cfg_ready, the request is accepted and i_tx_ratio and i_prescale are captured.
  - A valid request goes to DRAIN with the counter loaded to DRAIN_CYC.
  - An invalid request (checked only when the macro is defined) pulses o_cfg_err, stays in IDLE, and leaves the ratios unchanged.
- DRAIN: o_clk_en=0, o_busy=1. Counter decrements; at count 1, go to LOAD.
- LOAD (1 cycle): new ratios and o_rx_bypass are registered to the outputs. Then go to SETTLE with the counter loaded to SETTLE_CYC.
- SETTLE: o_clk_en=i_sys_en, o_busy=1. At count 1, go to IDLE.
- o_cfg_ready=0 in every state except IDLE; requests are stalled, not dropped.
- i_sys_en deasserting mid-sequence does not abort the sequence; it only gates o_clk_en.
- i_rst mid-sequence restores all reset values on the next edge; the captured request is discarded.

## Timing
- Accept edge k. After k: DRAIN, o_busy=1, o_clk_en=0, o_cfg_ready=0.
- After k+DRAIN_CYC: LOAD, new ratios visible.
- After k+DRAIN_CYC+1: SETTLE, o_clk_en=i_sys_en.
- After k+DRAIN_CYC+1+SETTLE_CYC: IDLE, o_busy=0, o_cfg_ready=1.
- Total busy: DRAIN_CYC+1+SETTLE_CYC cycles (19 with defaults).
- Rejected request: o_cfg_err=1 for the single cycle after k. o_cfg_ready stays 1, and a new request is accepted in that same cycle.
- Ratios never change while o_clk_en=1.

## Configuration
- Macro CLK_DIV_CTRL_CFG_CHECK_EN.
- Defined:
  - A request is rejected if i_tx_ratio < 2 or i_prescale ∉ {4,8,16,32}.
  - On rejection, o_cfg_err pulses and the current configuration is kept.
- Undefined:
  - No checking; o_cfg_err is tied to 0.
  - i_tx_ratio is loaded as given.
  - An unmapped prescale yields o_rx_div_ratio=0, o_rx_bypass=0.

## Structure
- Shared package clk_div_ctrl_pkg holds:
  - the state enum;
  - prescale constants PRESCALE_4/8/16/32;
  - the prescale→ratio mapping function returning {bypass, ratio};
  - the minimum divider ratio constant.
- One sub-module, clk_div_ctrl_map: a combinational prescale decoder that also produces the invalid flag. Everything else is in the top module.

## Test plan
- Reset with i_sys_en=1 → o_tx_div_ratio=8, o_rx_div_ratio=1, o_rx_bypass=1, o_cfg_ready=1. o_clk_en=1 one cycle after reset release.
- Request tx=6, prescale=8 at edge k → o_clk_en=0 for cycles k+1..k+17; ratios 6/4 after k+16; o_clk_en=1 after k+17; o_busy=0 after k+19.
- Request with i_cfg_valid held during busy → o_cfg_ready=0 throughout; accepted on the first IDLE cycle; second sequence applied.
- With the macro defined, request tx=1 or prescale=12 → one-cycle o_cfg_err, no DRAIN, ratios unchanged. With the macro undefined, the same request loads tx=1 with no o_cfg_err.
- i_rst asserted during DRAIN → next edge: IDLE, default ratios, o_busy=0.
- i_sys_en=0 during SETTLE → o_clk_en=0, sequence still completes on schedule.
